escaner_teclado: RTL and testbench
==================================

ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 Parameter FILAS, default 4, number of keypad rows (2..16).
REQ-002 Parameter COLUMNAS, default 4, number of keypad columns (2..16).
REQ-003 Parameter SCAN_DIV, default 1000, clock cycles each column strobe is held (>=2).
REQ-004 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles to accept a press or release (>=1).
REQ-005 Parameter DEFAULT_CODE, default 4'b0011 (key A) zero-extended to NW, code shown when no key is accepted.
REQ-006 Derived widths: RW = clog2(FILAS), CW = clog2(COLUMNAS), NW = RW+CW.
REQ-007 clk  input  1  single clock, all logic on rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 filas_in  input  FILAS  row sense lines, active-low (pulled up), already synchronised externally.
REQ-010 ack_in  input  1  consumer acknowledge of current code.
REQ-011 columnas_out  output  COLUMNAS  column strobes, active-low, at most one bit low.
REQ-012 num_out  output  NW  encoded key {row_index, column_index}.
REQ-013 valid_out  output  1  new accepted code pending acknowledge.
REQ-014 hold_out  output  1  a key is accepted and not yet released.

Function
REQ-015 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE_WAIT.
REQ-016 SCAN: columnas_out drives column c low for SCAN_DIV cycles; filas_in sampled on the last cycle; c then wraps COLUMNAS-1 -> 0.
REQ-017 SCAN sample with any row low: capture c and lowest-index low row (lowest index wins on multiple rows), enter DEBOUNCE holding column c, counter cleared.
REQ-018 DEBOUNCE: each cycle filas_in equals the captured pattern, counter increments; any mismatch returns to SCAN at column (c+1) mod COLUMNAS.
REQ-019 DEBOUNCE counter reaching DEBOUNCE_CYCLES: num_out <= {row, c}, valid_out <= 1, hold_out <= 1, enter PRESSED next cycle.
REQ-020 PRESSED: column c stays driven; valid_out stays 1 until ack_in sampled 1, then valid_out <= 0 and state RELEASE_WAIT.
REQ-021 ack_in while valid_out = 0 SHALL be ignored; ack_in in the first valid cycle clears valid_out the following cycle (valid high exactly 1 cycle).
REQ-022 Release before ack SHALL NOT drop valid_out or change num_out; release is evaluated only in RELEASE_WAIT.
REQ-023 RELEASE_WAIT: counter counts consecutive cycles with all filas_in high; any low row clears counter; reaching DEBOUNCE_CYCLES sets hold_out <= 0, num_out <= DEFAULT_CODE, enters SCAN at column 0.
REQ-024 num_out SHALL equal DEFAULT_CODE whenever hold_out = 0 and the latched code whenever hold_out = 1.
REQ-025 Counters SHALL be sized clog2(max(SCAN_DIV, DEBOUNCE_CYCLES)+1) bits and never wrap.
REQ-026 Column index arithmetic SHALL be modulo COLUMNAS for non-power-of-two counts.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst_n = 0 at a clock edge: state SCAN, column 0, counters 0, columnas_out = all ones except bit 0 low, num_out = DEFAULT_CODE, valid_out = 0, hold_out = 0.
REQ-029 Reset asserted mid-debounce, mid-press or mid-release SHALL abort immediately with no valid_out pulse.
REQ-030 First column strobe SHALL begin the cycle after rst_n returns to 1.

Verification (FILAS=4, COLUMNAS=4, SCAN_DIV=2, DEBOUNCE_CYCLES=4)
REQ-031 Idle, filas_in = 4'b1111 -> columnas_out cycles 1110,1101,1011,0111 every 2 cycles; num_out = 4'b0011, valid_out = 0.
REQ-032 Row 2 low while column 1 strobed, held stable -> after 4 stable cycles num_out = 4'b1001, valid_out = 1, hold_out = 1; ack_in pulse clears valid_out next cycle.
REQ-033 Bounce: row low 2 cycles then high during DEBOUNCE -> no valid_out, scan resumes at next column.
REQ-034 Rows 1 and 3 low on column 0 -> num_out = 4'b0100 (lowest row wins).
REQ-035 Key released before ack -> valid_out and num_out held until ack; after ack and 4 high cycles, hold_out = 0, num_out = 4'b0011, scan restarts at column 0.
REQ-036 rst_n low during PRESSED -> next edge all outputs at reset values, valid_out = 0.

Source files
------------

// File: rtl/escaner_teclado.sv
// Matrix keypad scanner: strobes one active-low column at a time, debounces the
// press and the release of the first key found, and offers its code to a consumer.
module escaner_teclado #(
    parameter int FILAS           = 4,
    parameter int COLUMNAS        = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DEFAULT_CODE    = 3,
    localparam int RW = $clog2(FILAS),
    localparam int CW = $clog2(COLUMNAS),
    localparam int NW = RW + CW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FILAS-1:0]    filas_in,
    input  logic                ack_in,
    output logic [COLUMNAS-1:0] columnas_out,
    output logic [NW-1:0]       num_out,
    output logic                valid_out,
    output logic                hold_out,
    output logic [1:0]          dbg_state_out
);

    // Handshake: valid_out rises together with a new num_out and stays high until
    // ack_in is sampled high on a clock edge; ack_in while valid_out is low is ignored.

    localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNTW    = $clog2(MAX_CNT + 1);
    localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_DIV - 1);
    localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [NW-1:0]   DEF_CODE  = NW'(DEFAULT_CODE);
    localparam logic [CW-1:0]   COL_LAST  = CW'(COLUMNAS - 1);

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_col;
    logic [CNTW-1:0]       r_cnt;
    logic [RW-1:0]         r_row;
    logic [FILAS-1:0]      r_pat;
    logic [COLUMNAS-1:0]   r_columnas;
    logic [NW-1:0]         r_num;
    logic                  r_valid;
    logic                  r_hold;

    logic [RW-1:0]         w_row;
    logic                  w_any;
    logic [CW-1:0]         w_col_next;

    function automatic logic [COLUMNAS-1:0] strobe(input logic [CW-1:0] c);
        logic [COLUMNAS-1:0] v;
        v = '1;
        v[c] = 1'b0;
        return v;
    endfunction

    // Descending loop so the lowest-index low row is the one left in w_row.
    always_comb begin
        w_row = '0;
        w_any = 1'b0;
        for (int i = FILAS - 1; i >= 0; i--) begin
            if (!filas_in[i]) begin
                w_row = RW'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_col_next = (r_col == COL_LAST) ? '0 : r_col + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_SCAN;
            r_col      <= '0;
            r_cnt      <= '0;
            r_row      <= '0;
            r_pat      <= '1;
            r_columnas <= strobe('0);
            r_num      <= DEF_CODE;
            r_valid    <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_cnt == SCAN_LAST) begin
                        r_cnt <= '0;
                        if (w_any) begin
                            r_row   <= w_row;
                            r_pat   <= filas_in;
                            r_state <= ST_DEBOUNCE;
                        end else begin
                            r_col      <= w_col_next;
                            r_columnas <= strobe(w_col_next);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (filas_in != r_pat) begin
                        r_cnt      <= '0;
                        r_col      <= w_col_next;
                        r_columnas <= strobe(w_col_next);
                        r_state    <= ST_SCAN;
                    end else if (r_cnt == DEB_LAST) begin
                        r_cnt   <= '0;
                        r_num   <= {r_row, r_col};
                        r_valid <= 1'b1;
                        r_hold  <= 1'b1;
                        r_state <= ST_PRESSED;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                // Release is deliberately not looked at until the code is acknowledged.
                ST_PRESSED: begin
                    if (ack_in) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_RELEASE_WAIT;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!(&filas_in)) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_cnt      <= '0;
                        r_hold     <= 1'b0;
                        r_num      <= DEF_CODE;
                        r_col      <= '0;
                        r_columnas <= strobe('0);
                        r_state    <= ST_SCAN;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    assign columnas_out  = r_columnas;
    assign num_out       = r_num;
    assign valid_out     = r_valid;
    assign hold_out      = r_hold;
    assign dbg_state_out = r_state;

endmodule

// File: tb/tb_escaner_teclado.sv
// Bench for escaner_teclado: a simulated key matrix drives filas_in from the
// column strobes; expected outputs come from an event timeline of each key press.
module tb_escaner_teclado;

    localparam int F   = 4;
    localparam int C   = 4;
    localparam int SD  = 2;
    localparam int DEB = 4;
    localparam int NW  = 4;
    localparam logic [NW-1:0] DEF = 4'b0011;

    typedef struct {
        logic [F*C-1:0] mask;
        int             pre;
        int             bounce;
        bit             rel_first;
        int             h;
        bit             glitch;
        int             abort_off;
        int             exp_code;
    } scn_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ack_in;
    logic [F-1:0]   filas_in;
    logic [C-1:0]   columnas_out;
    logic [NW-1:0]  num_out;
    logic           valid_out;
    logic           hold_out;
    logic [1:0]     dbg_state_out;
    logic [F*C-1:0] keys;

    int t;
    int t0;
    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    escaner_teclado #(
        .FILAS(F), .COLUMNAS(C), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB), .DEFAULT_CODE(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .filas_in(filas_in),
        .ack_in(ack_in),
        .columnas_out(columnas_out),
        .num_out(num_out),
        .valid_out(valid_out),
        .hold_out(hold_out),
        .dbg_state_out(dbg_state_out)
    );

    // Key (r,c) pulls row r low while column c is strobed low.
    always_comb begin
        for (int r = 0; r < F; r++) begin
            filas_in[r] = 1'b1;
            for (int c = 0; c < C; c++) begin
                if (keys[r*C+c] && !columnas_out[c]) filas_in[r] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int col, input logic [NW-1:0] num,
                              input logic v, input logic h);
        logic [C-1:0] ecol;
        ecol = '1;
        ecol[col] = 1'b0;
        @(negedge clk);
        chk({tag, " columnas_out"}, 32'(columnas_out), 32'(ecol));
        chk({tag, " num_out"}, 32'(num_out), 32'(num));
        chk({tag, " valid_out"}, 32'(valid_out), 32'(v));
        chk({tag, " hold_out"}, 32'(hold_out), 32'(h));
    endtask

    task automatic release_reset(input string tag);
        keys   = '0;
        ack_in = 1'b0;
        rst_n  = 1'b1;
        t0     = t;
        check_outs({tag, " reset"}, 0, DEF, 1'b0, 1'b0);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ack_in = 1'($urandom_range(0, 1));
            check_outs("idle", ((t - t0) / SD) % C, DEF, 1'b0, 1'b0);
            tick();
        end
        ack_in = 1'b0;
    endtask

    function automatic bit col_has(input logic [F*C-1:0] mk, input int c);
        for (int r = 0; r < F; r++) if (mk[r*C+c]) return 1'b1;
        return 1'b0;
    endfunction

    // One key-press episode: scan finds the first sampled column holding a key,
    // debounce, valid until ack, then release debounce back to column 0.
    task automatic run_scn(input scn_t s, input string tag);
        int ts, cw, rw, m, ta, tr, g, st, done, t_end, t_ab, col;
        logic [NW-1:0] code, en;
        logic v, h;
        bit aborted;
        idle(s.pre);
        ts = t;
        while (!(((ts - t0) % SD == SD - 1) && col_has(s.mask, ((ts - t0) / SD) % C))) ts++;
        cw = ((ts - t0) / SD) % C;
        rw = 0;
        while (!s.mask[rw*C+cw]) rw++;
        code  = (s.exp_code >= 0) ? NW'(s.exp_code) : NW'(rw * C + cw);
        m     = (s.bounce > 0) ? ts + 1 + s.bounce : -1;
        ta    = ts + DEB + 1 + s.h;
        tr    = s.rel_first ? ts + DEB + 1 + s.h / 2 : ta + 1 + s.h % 3;
        g     = s.glitch ? ((tr > ta + 1) ? tr : ta + 1) + 1 : -1;
        st    = s.glitch ? g + 1 : ((tr > ta + 1) ? tr : ta + 1);
        done  = st + DEB;
        t_end = (m >= 0) ? m + 1 : done;
        t_ab  = (s.abort_off >= 0) ? ts + 1 + s.abort_off : -1;
        aborted = 1'b0;
        while (t < t_end && !aborted) begin
            if (m >= 0) keys = (t < m) ? s.mask : '0;
            else        keys = (t < tr || t == g) ? s.mask : '0;
            if (t <= ts) begin
                col = ((t - t0) / SD) % C; en = DEF; v = 1'b0; h = 1'b0;
            end else if (t <= ts + DEB) begin
                col = cw; en = DEF; v = 1'b0; h = 1'b0;
            end else if (t <= ta) begin
                col = cw; en = code; v = 1'b1; h = 1'b1;
            end else begin
                col = cw; en = code; v = 1'b0; h = 1'b1;
            end
            ack_in = (t == ta) ? 1'b1 : (v ? 1'b0 : 1'($urandom_range(0, 1)));
            if (t == t_ab) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
            end
            check_outs(tag, col, en, v, h);
            tick();
        end
        ack_in = 1'b0;
        if (aborted)     release_reset(tag);
        else if (m >= 0) t0 = m + 1 - ((cw + 1) % C) * SD;
        else             t0 = done;
    endtask

    scn_t tbl[8];
    scn_t rs;
    int   nk;

    initial begin
        t = 0; t0 = 0; n_checks = 0; n_errors = 0;
        rst_n = 1'b0; ack_in = 1'b0; keys = '0;
        //          mask     pre bnc rel   h  gl   abort exp
        tbl[0] = '{16'h0200, 3, 0, 1'b0, 2, 1'b0, -1, 9};
        tbl[1] = '{16'h1010, 0, 0, 1'b0, 0, 1'b0, -1, 4};
        tbl[2] = '{16'h4000, 5, 0, 1'b1, 5, 1'b0, -1, 14};
        tbl[3] = '{16'h0040, 1, 2, 1'b0, 0, 1'b0, -1, 6};
        tbl[4] = '{16'h0002, 2, 0, 1'b0, 3, 1'b1, -1, 1};
        tbl[5] = '{16'h8000, 4, 0, 1'b0, 10, 1'b0, DEB + 1, 15};
        tbl[6] = '{16'h0100, 0, 0, 1'b0, 2, 1'b0, 1, 8};
        tbl[7] = '{16'h0020, 6, 0, 1'b0, 1, 1'b0, DEB + 2, 5};

        @(posedge clk);
        #1;
        tick();
        release_reset("init");
        idle(12);

        for (int i = 0; i < 8; i++) run_scn(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            rs.mask = '0;
            nk = int'($urandom_range(1, 3));
            for (int k = 0; k < nk; k++) rs.mask[$urandom_range(0, F*C-1)] = 1'b1;
            rs.pre       = int'($urandom_range(0, 9));
            rs.bounce    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DEB - 1)) : 0;
            rs.rel_first = 1'($urandom_range(0, 1));
            rs.h         = int'($urandom_range(0, 6));
            rs.glitch    = 1'($urandom_range(0, 1));
            rs.abort_off = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEB + 10)) : -1;
            rs.exp_code  = -1;
            run_scn(rs, $sformatf("rnd%0d", i));
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
